// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO pointer/control slice.
// The FWFT state enum is only referenced when FIFO_PTR_CTRL_FWFT_EN is defined.
package fifo_pkg;

    localparam int unsigned PTR_W = 4;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fwft_state_e;

    // Number of RAM entries addressed by a K-bit wrap-bit pointer.
    function automatic int unsigned depth(input int unsigned k);
        return 32'd1 << (k - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// K-bit enabled wrap-bit pointer counter; the MSB toggles every 2**(K-1) increments.
module fifo_ptr #(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [K-1:0] ptr
);

    logic [K-1:0] ptr_q;
    logic [K-1:0] ptr_d;

    // Next pointer value: advance by one when enabled.
    always_comb begin
        if (en) begin
            ptr_d = ptr_q + {{(K-1){1'b0}}, 1'b1};
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Read/write control for a synchronous FIFO driving an external sync-read dual-port RAM.
// Define FIFO_PTR_CTRL_FWFT_EN to present the head word first-word-fall-through.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int K = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic           rd_en,
    output logic           full,
    output logic           empty,
    output logic           overflow,
    output logic           underflow,
    output logic [K-1:0]   wr_ptr,
    output logic [K-1:0]   rd_ptr,
    output logic [K-1:0]   count,
    output logic           ram_we,
    output logic [K-2:0]   ram_waddr,
    output logic           ram_re,
    output logic [K-2:0]   ram_raddr,
    input  logic [W-1:0]   ram_rdata,
    output logic [W-1:0]   dout,
    output logic           dout_valid
);

    localparam int unsigned DEPTH = depth(K);

    logic           wr_acc_s;
    logic           rd_acc_s;
    logic           pop_s;
    logic           ram_re_s;
    logic           ram_empty_s;
    logic [K-1:0]   wr_nxt_s;
    logic [K-1:0]   rd_nxt_s;

    logic           full_q,      full_d;
    logic           empty_q,     empty_d;
    logic           overflow_q,  overflow_d;
    logic           underflow_q, underflow_d;
    logic [K-1:0]   count_q,     count_d;
    logic [W-1:0]   dout_q,      dout_d;
`ifdef FIFO_PTR_CTRL_FWFT_EN
    fwft_state_e    state_q,     state_d;
`else
    logic           rd_valid_q,  rd_valid_d;
`endif

    fifo_ptr #(.K(K)) u_wr_ptr (.clk(clk), .rst_n(rst_n), .en(wr_acc_s), .ptr(wr_ptr));
    fifo_ptr #(.K(K)) u_rd_ptr (.clk(clk), .rst_n(rst_n), .en(pop_s),    .ptr(rd_ptr));

    // Request acceptance, RAM strobes and read-side next state.
    always_comb begin
        ram_empty_s = (wr_ptr == rd_ptr);
        wr_acc_s    = wr_en && !full_q;
        dout_d      = dout_q;
`ifdef FIFO_PTR_CTRL_FWFT_EN
        rd_acc_s    = rd_en && (state_q != EMPTY);
        ram_re_s    = 1'b0;
        state_d     = state_q;
        case (state_q)
            EMPTY: begin
                ram_re_s = !ram_empty_s;
                state_d  = ram_empty_s ? EMPTY : FETCH;
            end
            FETCH, VALID: begin
                if (rd_acc_s) begin
                    ram_re_s = !ram_empty_s;
                    state_d  = ram_empty_s ? EMPTY : FETCH;
                end else if (state_q == FETCH) begin
                    dout_d  = ram_rdata;
                    state_d = VALID;
                end else begin
                    state_d = VALID;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
`else
        rd_acc_s    = rd_en && !empty_q;
        ram_re_s    = rd_acc_s;
        rd_valid_d  = pop_s;
        if (rd_valid_q) begin
            dout_d = ram_rdata;
        end else begin
            dout_d = dout_q;
        end
`endif
        pop_s       = ram_re_s && !ram_empty_s;
        wr_nxt_s    = wr_ptr + {{(K-1){1'b0}}, wr_acc_s};
        rd_nxt_s    = rd_ptr + {{(K-1){1'b0}}, pop_s};
        // Occupancy of exactly DEPTH is the same as "indices equal, wrap bits differ".
        count_d     = wr_nxt_s - rd_nxt_s;
        full_d      = (count_d == K'(DEPTH));
`ifdef FIFO_PTR_CTRL_FWFT_EN
        empty_d     = (state_d == EMPTY);
`else
        empty_d     = (count_d == '0);
`endif
        overflow_d  = wr_en && full_q;
        underflow_d = rd_en && empty_q;
    end

    // Flags, occupancy, output register and FWFT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            count_q     <= '0;
            dout_q      <= '0;
`ifdef FIFO_PTR_CTRL_FWFT_EN
            state_q     <= EMPTY;
`else
            rd_valid_q  <= 1'b0;
`endif
        end else begin
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
`ifdef FIFO_PTR_CTRL_FWFT_EN
            state_q     <= state_d;
`else
            rd_valid_q  <= rd_valid_d;
`endif
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;
    assign ram_we    = wr_acc_s;
    assign ram_re    = ram_re_s;
    assign ram_waddr = wr_ptr[K-2:0];
    assign ram_raddr = rd_ptr[K-2:0];
`ifdef FIFO_PTR_CTRL_FWFT_EN
    // In FETCH the head word is still on the RAM read port.
    assign dout       = (state_q == FETCH) ? ram_rdata : dout_q;
    assign dout_valid = !empty_q;
`else
    assign dout       = rd_valid_q ? ram_rdata : dout_q;
    assign dout_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: queue-based reference model plus directed literals.
// With FIFO_PTR_CTRL_FWFT_EN defined, a directed FWFT sequence runs instead of the model.
module tb_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en;
    logic       full, empty, overflow, underflow;
    logic [3:0] wr_ptr, rd_ptr, count;
    logic       ram_we, ram_re;
    logic [2:0] ram_waddr, ram_raddr;
    logic [7:0] ram_rdata = 8'h00;
    logic [7:0] dout;
    logic       dout_valid;
    logic [7:0] wdata;
    logic [7:0] mem [8];

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    int q[$];
    int wr_cnt = 0, rd_cnt = 0;
    int exp_dout = 0;
    bit exp_dv = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;

    fifo_ptr_ctrl #(.K(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    // External synchronous-read RAM.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic check_reset();
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_rd_ptr", rd_ptr, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
    endtask

    task automatic model_clear();
        q.delete();
        wr_cnt = 0; rd_cnt = 0; exp_dout = 0;
        exp_dv = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    endtask

    task automatic drv(input bit w, input bit r, input logic [7:0] d);
        wr_en = w; rd_en = r; wdata = d;
        @(posedge clk);
        @(negedge clk);
    endtask

`ifndef FIFO_PTR_CTRL_FWFT_EN
    // One cycle: drive, check strobes, advance model at the edge, check registered outputs.
    task automatic step(input bit w, input bit r, input logic [7:0] d);
        int sz;
        bit wa, ra;
        wr_en = w; rd_en = r; wdata = d;
        #1;
        sz = q.size();
        wa = w && (sz != 8);
        ra = r && (sz != 0);
        chk("ram_we", ram_we, wa);
        chk("ram_re", ram_re, ra);
        chk("ram_waddr", ram_waddr, wr_cnt % 8);
        chk("ram_raddr", ram_raddr, rd_cnt % 8);
        @(posedge clk);
        exp_ovf = w && (sz == 8);
        exp_unf = r && (sz == 0);
        exp_dv  = ra;
        if (ra) exp_dout = q.pop_front();
        if (wa) q.push_back(int'(d));
        wr_cnt += int'(wa);
        rd_cnt += int'(ra);
        @(negedge clk);
        chk("full", full, int'(q.size() == 8));
        chk("empty", empty, int'(q.size() == 0));
        chk("count", count, q.size());
        chk("wr_ptr", wr_ptr, wr_cnt % 16);
        chk("rd_ptr", rd_ptr, rd_cnt % 16);
        chk("overflow", overflow, int'(exp_ovf));
        chk("underflow", underflow, int'(exp_unf));
        chk("dout_valid", dout_valid, int'(exp_dv));
        chk("dout", dout, exp_dout);
    endtask
`endif

    initial begin
        int exp_f[4];
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
        #23;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
`ifndef FIFO_PTR_CTRL_FWFT_EN
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
        chk("fill_full", full, 1);
        chk("fill_wr_ptr", wr_ptr, 4'b1000);
        chk("fill_count", count, 8);
        step(1'b1, 1'b0, 8'hEE);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_wr_ptr", wr_ptr, 4'b1000);
        step(1'b1, 1'b1, 8'h99);
        chk("full_both_full", full, 0);
        chk("full_both_count", count, 7);
        chk("full_both_dout", dout, 8'h10);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("drain_dout", dout, 8'h10 + i);
        end
        chk("drain_empty", empty, 1);
        chk("drain_rd_ptr", rd_ptr, 4'b1000);
        step(1'b0, 1'b1, 8'h00);
        chk("unf_pulse", underflow, 1);
        step(1'b1, 1'b1, 8'h42);
        chk("empty_both_unf", underflow, 1);
        chk("empty_both_count", count, 1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(i + 8'h60));
        chk("stream_count", count, 1);
        step(1'b0, 1'b1, 8'h00);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < ((p % 2 == 0) ? 80 : 25),
                     $urandom_range(0, 99) < ((p % 2 == 0) ? 25 : 80),
                     8'($urandom));
            end
        end
        while (q.size() < 5) step(1'b1, 1'b0, 8'($urandom));
        while (q.size() > 5) step(1'b0, 1'b1, 8'h00);
        chk("pre_rst_count", count, 5);
        #2 rst_n = 1'b0;
        #1;
        check_reset();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h5C);
        step(1'b0, 1'b1, 8'h00);
        chk("post_rst_dout", dout, 8'h5C);
`else
        drv(1'b1, 1'b0, 8'hA5);
        chk("fwft_empty_1edge", empty, 1);
        drv(1'b0, 1'b0, 8'h00);
        chk("fwft_empty", empty, 0);
        chk("fwft_dout", dout, 8'hA5);
        chk("fwft_dout_valid", dout_valid, 1);
        for (int i = 1; i <= 3; i++) drv(1'b1, 1'b0, 8'(i));
        chk("fwft_head_held", dout, 8'hA5);
        chk("fwft_count", count, 3);
        exp_f[0] = 8'hA5; exp_f[1] = 1; exp_f[2] = 2; exp_f[3] = 3;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b0; rd_en = 1'b1;
            #1;
            chk("fwft_stream_dout", dout, exp_f[i]);
            chk("fwft_stream_valid", dout_valid, 1);
            @(posedge clk);
            @(negedge clk);
        end
        rd_en = 1'b0;
        chk("fwft_drained", empty, 1);
        drv(1'b0, 1'b1, 8'h00);
        chk("fwft_unf", underflow, 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Read/write control stage of the synchronous FIFO. Owns the wrap-bit write and read pointers, registers the full/empty flags, and drives an external dual-port synchronous-read RAM. Under a compile-time option it also presents the head word first-word-fall-through (FWFT).

## Interface
- K, 4, pointer width including wrap bit; DEPTH = 2**(K-1) RAM entries
- W, 8, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- rd_en  in  1  read request
- full  out  1  registered; RAM full
- empty  out  1  registered; no readable word
- overflow  out  1  one-cycle pulse, cycle after a rejected write
- underflow  out  1  one-cycle pulse, cycle after a rejected read
- wr_ptr  out  K  write pointer, MSB = wrap bit
- rd_ptr  out  K  read pointer, MSB = wrap bit
- count  out  K  RAM occupancy, wr_ptr - rd_ptr mod 2**K
- ram_we  out  1  RAM write strobe
- ram_waddr  out  K-1  wr_ptr[K-2:0]
- ram_re  out  1  RAM read strobe
- ram_raddr  out  K-1  rd_ptr[K-2:0]
- ram_rdata  in  W  RAM read data, valid the cycle after ram_re
- dout  out  W  read data
- dout_valid  out  1  dout holds a popped/head word

## Operation
- Write accepted: wr_en && !full. Then ram_we = 1 (combinational) and wr_ptr += 1 at the edge.
- RAM pop: ram_re && !ram_empty. Then rd_ptr += 1 at the edge.
- ram_empty = (wr_ptr == rd_ptr). ram_full = (wr_ptr[K-2:0] == rd_ptr[K-2:0]) && (wr_ptr[K-1] != rd_ptr[K-1]).
- Flags are computed from next-state pointers and registered, so they are exact in the cycle after the update.
- Pointers wrap modulo 2**K. The wrap bit toggles every DEPTH increments.
- Simultaneous write and pop: both are taken.
  - When full, the write is rejected regardless of rd_en.
  - When empty, the read is rejected regardless of wr_en.
- Any write accepted in a cycle becomes readable only in the following cycle; there is no bypass.
- overflow/underflow are raised on rejected requests only.

## Timing
- Reset values (asynchronous): wr_ptr = rd_ptr = 0, count = 0, full = 0, empty = 1, overflow = underflow = 0, dout = 0, dout_valid = 0, FSM = EMPTY.
- Reset mid-operation discards all contents. The first request after deassertion is honoured on the first rising edge.
- Standard mode:
  - ram_re = rd_en && !empty.
  - dout = ram_rdata and dout_valid = 1 in the cycle after the accepted read.
  - Read latency is 1 cycle.
  - empty falls 1 cycle after the first write edge.
  - Throughput is 1 word/cycle each side.

## Configuration
- Macro: FIFO_PTR_CTRL_FWFT_EN.
- Undefined: standard mode as above.
- Defined: FWFT mode. empty = (state == EMPTY), dout_valid = !empty, and a read is accepted when rd_en && !empty.
- FWFT FSM:
  - EMPTY: if !ram_empty, issue ram_re and go to FETCH.
  - FETCH: dout = ram_rdata.
    - Accepted read and !ram_empty: issue ram_re, stay in FETCH.
    - Accepted read and ram_empty: go to EMPTY.
    - No read: capture ram_rdata into the output register, go to VALID.
  - VALID: dout = output register.
    - Accepted read and !ram_empty: issue ram_re, go to FETCH.
    - Accepted read and ram_empty: go to EMPTY.
    - Otherwise hold.
- FWFT timing and capacity:
  - First word visible 2 edges after the write edge.
  - Sustained 1 word/cycle, no bubbles.
  - Capacity is DEPTH+1: full reflects RAM only; count excludes the head word.

## Structure
- Package fifo_pkg holds:
  - the FSM enum (EMPTY, FETCH, VALID),
  - the DEPTH function of K,
  - the pointer type.
- Sub-module fifo_ptr is a K-bit enabled wrap-bit counter with async reset, instantiated twice (write and read).
- Flag logic, FSM and output register stay in the top.

## Test plan
- Reset, then K=4, write 8 words 0x10..0x17 -> full = 1 after the 8th edge; wr_ptr = 4'b1000; count = 8; 9th write gives overflow pulse and no pointer change.
- Read all 8 from full -> dout 0x10..0x17 in order; empty = 1 after the 8th; rd_ptr = 4'b1000; extra read gives underflow pulse.
- Continuous simultaneous write/read for 40 cycles across two wraps -> count constant; data in order; no flag glitches.
- Full plus wr_en and rd_en in the same cycle -> read taken, write rejected, full falls next cycle; empty plus both -> write taken, read rejected.
- FWFT: single write of 0xA5 into empty -> dout = 0xA5 with empty = 0 two edges later without rd_en; back-to-back reads of 3 words show no bubble.
- Assert rst_n low mid-stream with count = 5 -> all outputs at reset values immediately; next write is read back as the first word.
